// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-request instruction fetch stage with a one-entry
// output buffer, redirect/squash handling and halt/resume control.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a misaligned
// redirect target traps to TRAP_PC. When undefined, the target's low bits
// are cleared and trap stays 0.
module pc_fetch_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] TRAP_PC  = PC_W'(8'h10)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic            trap
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] if_pc_q;
  logic [31:0]     if_inst_q;
  logic            if_valid_q;
  logic            halted_q;
  logic            trap_q;
  logic            squash_q;

  logic [PC_W-1:0] redir_pc;
  logic            redir_trap;
  logic            ack_live;
  logic            xfer;
  logic            room;
  logic            in_flight;

`ifdef MISALIGN_TRAP_EN
  // Resolve the redirect destination: misaligned targets divert to the trap vector.
  always_comb begin
    redir_pc   = {redirect_target[PC_W-1:2], 2'b00};
    redir_trap = 1'b0;
    if (redirect_target[1:0] != 2'b00) begin
      redir_pc   = TRAP_PC;
      redir_trap = 1'b1;
    end
  end
`else
  assign redir_pc   = {redirect_target[PC_W-1:2], 2'b00};
  assign redir_trap = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{redirect_target[1:0], TRAP_PC};
`endif

  // An ack is only usable in FETCH and when it does not belong to a squashed request.
  assign ack_live  = (state_q == S_FETCH) & imem_ack & ~squash_q;
  assign xfer      = if_valid_q & if_ready;
  assign room      = ~if_valid_q | if_ready;
  // A request is still with the memory if one was issued and its ack has not come back.
  assign in_flight = ((state_q == S_FETCH) | squash_q) & ~imem_ack;

  assign imem_req  = (state_q == S_FETCH) & ~rst;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign halted    = halted_q;
  assign trap      = trap_q;

  // Fetch FSM, PC, output buffer and squash tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      trap_q   <= 1'b0;
      squash_q <= squash_q & ~imem_ack;
      if (redirect_valid || halt_req) begin
        if_valid_q <= 1'b0;
        squash_q   <= in_flight;
        if (redirect_valid) begin
          pc_q   <= redir_pc;
          trap_q <= redir_trap;
        end
        if (halt_req || (state_q == S_HALT && !resume)) begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end else begin
          state_q  <= S_FETCH;
          halted_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (ack_live && room) begin
              if_inst_q  <= imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              pc_q       <= pc_q + PC_W'(4);
              if (!if_ready) state_q <= S_HOLD;
            end else if (ack_live) begin
              // Buffer full and stalled: drop the word but leave PC on it,
              // so it is fetched again once the buffer drains.
              state_q <= S_HOLD;
            end else if (xfer) begin
              if_valid_q <= 1'b0;
            end
          end
          S_HOLD: begin
            if (xfer) begin
              if_valid_q <= 1'b0;
              state_q    <= S_FETCH;
            end
          end
          S_HALT: begin
            if (resume) begin
              state_q  <= S_FETCH;
              halted_q <= 1'b0;
            end
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (default PC_W=8). The reference model
// tracks the program-order address the consumer must see next, the halted
// flag and the expected trap pulse; a behavioural memory answers requests.
module tb_pc_fetch_unit;

  localparam int unsigned PC_W     = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam logic [7:0]  TRAP_PC  = 8'h10;
`ifdef MISALIGN_TRAP_EN
  localparam logic [7:0]  EXP_42   = 8'h10;
  localparam logic        TRAP_ON  = 1'b1;
`else
  localparam logic [7:0]  EXP_42   = 8'h40;
  localparam logic        TRAP_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [7:0]  if_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        halted;
  logic        trap;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .resume(resume), .halted(halted), .trap(trap)
  );

  int unsigned ncmp = 0;
  int unsigned nerr = 0;
  int unsigned nxfer = 0;

  // memory model
  logic        mbusy = 1'b0;
  logic [7:0]  maddr = '0;
  int unsigned mcnt = 0;
  int unsigned lat_min = 0;
  int unsigned lat_max = 0;

  // reference model
  logic [7:0]  exp_pc = RESET_PC;
  logic        exp_trap = 1'b0;
  logic        mh = 1'b0;
  logic        hold_chk = 1'b0;
  logic [7:0]  hold_pc = '0;
  logic [31:0] hold_inst = '0;

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'hC0DE_0000 ^ {a, 8'h00, ~a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory responds, outputs are checked against the model,
  // the model absorbs this cycle's redirect/halt/resume, then the edge.
  task automatic step();
    imem_ack = 1'b0;
    if (!rst) begin
      if (!mbusy && imem_req) begin
        mbusy = 1'b1;
        maddr = imem_addr;
        mcnt  = $urandom_range(lat_max, lat_min);
      end
      if (mbusy) begin
        if (mcnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = word(maddr);
        end else begin
          mcnt--;
        end
      end
      chk("trap", 32'(trap), 32'(exp_trap));
      chk("halted", 32'(halted), 32'(mh));
      if (mh) begin
        chk("req_in_halt", 32'(imem_req), 32'(0));
        chk("valid_in_halt", 32'(if_valid), 32'(0));
      end
      if (hold_chk) begin
        chk("stall_valid", 32'(if_valid), 32'(1));
        chk("stall_pc", 32'(if_pc), 32'(hold_pc));
        chk("stall_inst", if_inst, hold_inst);
      end
      if (if_valid && if_ready) begin
        chk("xfer_pc", 32'(if_pc), 32'(exp_pc));
        chk("xfer_inst", if_inst, word(exp_pc));
        exp_pc = exp_pc + 8'd4;
        nxfer++;
      end
      hold_chk  = if_valid && !if_ready && !redirect_valid && !halt_req;
      hold_pc   = if_pc;
      hold_inst = if_inst;
      exp_trap  = 1'b0;
      if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
        if (redirect_target[1:0] != 2'b00) begin
          exp_pc   = TRAP_PC;
          exp_trap = 1'b1;
        end else begin
          exp_pc = redirect_target;
        end
`else
        exp_pc = redirect_target & 8'hFC;
`endif
      end
      if (halt_req) mh = 1'b1;
      else if (resume) mh = 1'b0;
    end
    @(posedge clk);
    #1;
    if (imem_ack) mbusy = 1'b0;
    imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    resume = 1'b0;
    imem_ack = 1'b0;
    mbusy = 1'b0;
    #1;
    chk("rst_valid", 32'(if_valid), 32'(0));
    chk("rst_inst", if_inst, 32'(0));
    chk("rst_pc", 32'(if_pc), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
    chk("rst_trap", 32'(trap), 32'(0));
    chk("rst_req", 32'(imem_req), 32'(0));
    chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    @(posedge clk);
    #1;
    chk("rst_req_edge", 32'(imem_req), 32'(0));
    rst = 1'b0;
    #1;
    chk("req_after_rst", 32'(imem_req), 32'(1));
    exp_pc = RESET_PC;
    exp_trap = 1'b0;
    mh = 1'b0;
    hold_chk = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!if_valid && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(if_valid), 32'(1));
  endtask

  initial begin
    int unsigned n;

    // reset, then ack in the same cycle as each request, consumer always ready
    lat_min = 0; lat_max = 0; if_ready = 1'b1;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("seq_valid", 32'(if_valid), 32'(1));
      chk("seq_pc", 32'(if_pc), 32'(i * 4));
      chk("seq_inst", if_inst, word(8'(i * 4)));
      step();
    end

    // consumer stalls for 3 cycles after the first valid word
    if_ready = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(imem_req), 32'(0));
      chk("stall_addr", 32'(imem_addr), 32'(4));
      chk("stall_pc0", 32'(if_pc), 32'(0));
      step();
    end
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // redirect while a fetch is outstanding: stale ack must be dropped
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(mbusy && mcnt > 0 && imem_req) && n < 20) begin step(); n++; end
    chk("outstanding_found", 32'(mbusy && mcnt > 0), 32'(1));
    redirect_valid = 1'b1; redirect_target = 8'h40;
    step();
    redirect_valid = 1'b0;
    wait_valid("wait_40");
    chk("redir_pc_40", 32'(if_pc), 32'h40);

    // redirect in the very cycle the ack returns
    n = 0;
    while (!(mbusy && mcnt == 0) && n < 20) begin step(); n++; end
    chk("ack_next_found", 32'(mbusy && mcnt == 0), 32'(1));
    redirect_valid = 1'b1; redirect_target = 8'h80;
    step();
    redirect_valid = 1'b0;
    wait_valid("wait_80");
    chk("redir_pc_80", 32'(if_pc), 32'h80);

    // halt on the transfer of 0x08, resume after 5 halted cycles
    lat_min = 0; lat_max = 0;
    do_reset();
    step(); step(); step();
    chk("at_08", 32'(if_pc), 32'h08);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("halted_hold", 32'(halted), 32'(1));
      chk("halt_req_low", 32'(imem_req), 32'(0));
      if (i == 4) resume = 1'b1;
      step();
    end
    resume = 1'b0;
    chk("resumed", 32'(halted), 32'(0));
    wait_valid("wait_0c");
    chk("after_halt_pc", 32'(if_pc), 32'h0C);

    // halt and redirect together, then a redirect while halted
    redirect_valid = 1'b1; redirect_target = 8'h20; halt_req = 1'b1;
    step();
    redirect_valid = 1'b0; halt_req = 1'b0;
    chk("hr_halted", 32'(halted), 32'(1));
    chk("hr_addr", 32'(imem_addr), 32'h20);
    redirect_valid = 1'b1; redirect_target = 8'h24;
    step();
    redirect_valid = 1'b0;
    chk("halt_redir_stay", 32'(halted), 32'(1));
    chk("halt_redir_addr", 32'(imem_addr), 32'h24);
    resume = 1'b1;
    step();
    resume = 1'b0;
    wait_valid("wait_24");
    chk("resume_pc_24", 32'(if_pc), 32'h24);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_target = 8'hFC;
    step();
    redirect_valid = 1'b0;
    wait_valid("wait_fc");
    chk("wrap_fc", 32'(if_pc), 32'hFC);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    step();
    wait_valid("wait_00");
    chk("wrap_pc_00", 32'(if_pc), 32'h00);

    // misaligned redirect
    redirect_valid = 1'b1; redirect_target = 8'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_trap", 32'(trap), 32'(TRAP_ON));
    step();
    chk("mis_trap_pulse", 32'(trap), 32'(0));
    wait_valid("wait_mis");
    chk("mis_pc", 32'(if_pc), 32'(EXP_42));

    // randomized traffic against the model
    lat_min = 0; lat_max = 3;
    n = nxfer;
    for (int c = 0; c < 800; c++) begin
      if_ready = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(99, 0) < 5);
      redirect_target = 8'($urandom);
      if ($urandom_range(3, 0) != 0) redirect_target[1:0] = 2'b00;
      halt_req = (!if_valid || if_ready) && ($urandom_range(99, 0) < 3);
      resume = halted && ($urandom_range(9, 0) < 3);
      step();
    end
    redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    chk("progress", 32'((nxfer - n) > 100), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8: width of PC and all addresses, legal range 8..32.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_PC, default 8'h10: misalignment trap target, used only with MISALIGN_TRAP_EN.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-007 SHALL have port imem_addr, output, PC_W: fetch address, equal to PC while imem_req=1.
REQ-008 SHALL have port imem_ack, input, 1: memory returns imem_rdata this cycle; 1..N cycle latency.
REQ-009 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-010 SHALL have port if_valid, output, 1: if_inst/if_pc hold a valid instruction.
REQ-011 SHALL have port if_ready, input, 1: consumer accepts; transfer when if_valid and if_ready are both 1.
REQ-012 SHALL have port if_inst, output, 32 and port if_pc, output, PC_W: instruction and its address.
REQ-013 SHALL have port redirect_valid, input, 1 and redirect_target, input, PC_W: branch/jump target.
REQ-014 SHALL have port halt_req, input, 1 (EBREAK decoded) and resume, input, 1.
REQ-015 SHALL have port halted, output, 1 and trap, output, 1 (one-cycle pulse).

Function
REQ-016 SHALL implement FSM states FETCH (request issued, waiting ack), HOLD (output buffer full, consumer not ready), HALT.
REQ-017 In FETCH, imem_req SHALL be 1 and at most one request SHALL be outstanding.
REQ-018 On imem_ack in FETCH without redirect, if_inst<=imem_rdata, if_pc<=PC, if_valid<=1, PC<=PC+4 modulo 2^PC_W.
REQ-019 Fetch SHALL continue (back-to-back) if the buffer drains in the same cycle; otherwise the FSM SHALL enter HOLD with imem_req=0 until transfer.
REQ-020 Redirect SHALL have priority over sequential update: PC<=redirect_target, if_valid<=0 next cycle, and any in-flight ack SHALL be discarded (squash flag cleared by the ack).
REQ-021 A redirect simultaneous with imem_ack SHALL discard that ack's data.
REQ-022 halt_req SHALL take effect after the current transfer: if_valid<=0, outstanding ack discarded, state HALT, halted=1, PC unchanged.
REQ-023 In HALT imem_req SHALL be 0; resume SHALL return to FETCH at PC; redirect in HALT SHALL update PC without leaving HALT.
REQ-024 halt_req and redirect_valid in the same cycle: redirect SHALL update PC, then HALT.
REQ-025 if_inst and if_pc SHALL be stable while if_valid=1 and if_ready=0.
REQ-026 PC wrap-around from 2^PC_W-4 SHALL yield 0 without error.

Reset
REQ-027 On rst=1, immediately: PC=RESET_PC, state FETCH, if_valid=0, if_inst=0, if_pc=0, halted=0, trap=0, squash=0.
REQ-028 imem_req SHALL be 0 while rst=1 and SHALL assert the first cycle after deassertion.
REQ-029 Reset mid-fetch SHALL discard the outstanding ack arriving after reset release (squash=1 on release when a request was pending is not required; memory is reset with the same rst).

Configuration
REQ-030 Macro MISALIGN_TRAP_EN SHALL, when defined, treat redirect_target[1:0]!=0 as a trap: PC<=TRAP_PC, trap=1 for one cycle.
REQ-031 Without MISALIGN_TRAP_EN, redirect_target[1:0] SHALL be forced to 0 and trap SHALL be tied 0.

Verification
REQ-032 Reset then ack every cycle, if_ready=1 -> if_pc sequence 0,4,8,12 with matching if_inst.
REQ-033 if_ready=0 for 3 cycles after first valid -> if_inst/if_pc held, imem_req=0, no PC advance.
REQ-034 Redirect to 8'h40 during outstanding fetch -> stale ack dropped, next if_pc=8'h40.
REQ-035 halt_req at if_pc=8'h08, resume 5 cycles later -> halted=1 for 5 cycles, next if_pc=8'h0C.
REQ-036 PC_W=8, PC=8'hFC, ack -> next fetch address 8'h00.
REQ-037 With MISALIGN_TRAP_EN, redirect_target=8'h42 -> trap pulse, next if_pc=TRAP_PC; without it -> next if_pc=8'h40.
